// File: rtl/tlp_frag_multi_buffer.sv
// Circular TLP buffer with variable-width multi-location write and read per cycle.
// Define TLP_BUF_RD_REG_EN for a registered read port; otherwise rd_data is show-ahead.
module tlp_frag_multi_buffer #(
    parameter int LOC_WIDTH = 128,
    parameter int DEPTH     = 256,
    parameter int WR_LOCS   = 2,
    parameter int RD_LOCS   = 4,
    parameter int AF_THRESH = 8,
    parameter int CNT_W     = $clog2(DEPTH) + 1,
    parameter int WR_NUM_W  = $clog2(WR_LOCS + 1),
    parameter int RD_NUM_W  = $clog2(RD_LOCS + 1)
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [WR_NUM_W-1:0]          wr_num,
    input  logic [WR_LOCS*LOC_WIDTH-1:0] wr_data,
    output logic [CNT_W-1:0]             empty_loc,
    output logic                         almost_full,
    input  logic                         rd_en,
    input  logic [RD_NUM_W-1:0]          rd_num,
    output logic [RD_LOCS*LOC_WIDTH-1:0] rd_data,
    output logic                         rd_valid,
    output logic [CNT_W-1:0]             count,
    output logic                         ovf_err,
    output logic                         udf_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [LOC_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 wr_ok, rd_ok;
    logic                 wr_acc, rd_acc;
    logic                 wr_rej, rd_rej;
    logic [CNT_W-1:0]     count_next;

    assign empty_loc   = CNT_W'(DEPTH) - count;
    assign almost_full = (empty_loc < CNT_W'(AF_THRESH));

    // Acceptance uses only pre-cycle occupancy; flush suppresses both sides and their errors.
    assign wr_ok  = (wr_num <= WR_NUM_W'(WR_LOCS)) && (CNT_W'(wr_num) <= empty_loc);
    assign rd_ok  = (rd_num <= RD_NUM_W'(RD_LOCS)) && (CNT_W'(rd_num) <= count);
    assign wr_acc = wr_en && !flush && (wr_num != '0) && wr_ok;
    assign rd_acc = rd_en && !flush && (rd_num != '0) && rd_ok;
    assign wr_rej = wr_en && !flush && (wr_num != '0) && !wr_ok;
    assign rd_rej = rd_en && !flush && (rd_num != '0) && !rd_ok;

    always_comb begin
        count_next = count;
        if (wr_acc) count_next = count_next + CNT_W'(wr_num);
        if (rd_acc) count_next = count_next - CNT_W'(rd_num);
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < WR_LOCS; i++) begin
                if (WR_NUM_W'(i) < wr_num)
                    mem[wr_ptr + PTR_W'(i)] <= wr_data[i*LOC_WIDTH +: LOC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(wr_num);
            if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(rd_num);
            count <= count_next;
            if (wr_rej) ovf_err <= 1'b1;
            if (rd_rej) udf_err <= 1'b1;
        end
    end

`ifdef TLP_BUF_RD_REG_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                for (int i = 0; i < RD_LOCS; i++) begin
                    if (RD_NUM_W'(i) < rd_num)
                        rd_data[i*LOC_WIDTH +: LOC_WIDTH] <= mem[rd_ptr + PTR_W'(i)];
                    else
                        rd_data[i*LOC_WIDTH +: LOC_WIDTH] <= '0;
                end
            end
        end
    end
`else
    // Show-ahead: the oldest stored locations are always presented, unused slots zeroed.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < RD_LOCS; i++) begin
            if (CNT_W'(i) < count)
                rd_data[i*LOC_WIDTH +: LOC_WIDTH] = mem[rd_ptr + PTR_W'(i)];
        end
    end

    assign rd_valid = rd_acc;
`endif

endmodule

// File: tb/tb_tlp_frag_multi_buffer.sv
// Directed bench for tlp_frag_multi_buffer at default parameters; follows TLP_BUF_RD_REG_EN.
module tb_tlp_frag_multi_buffer;

    logic         clk = 1'b0;
    logic         arst_n;
    logic         flush;
    logic         wr_en;
    logic [1:0]   wr_num;
    logic [255:0] wr_data;
    logic [8:0]   empty_loc;
    logic         almost_full;
    logic         rd_en;
    logic [2:0]   rd_num;
    logic [511:0] rd_data;
    logic         rd_valid;
    logic [8:0]   count;
    logic         ovf_err;
    logic         udf_err;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [127:0] DA = 128'hAAAA_0001;
    localparam logic [127:0] DB = 128'hBBBB_0002;
    localparam logic [127:0] DC = 128'hCCCC_0003;
    localparam logic [127:0] DD = 128'hDDDD_0004;
    localparam logic [127:0] DE = 128'hEEEE_0005;

    tlp_frag_multi_buffer dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_num      (wr_num),
        .wr_data     (wr_data),
        .empty_loc   (empty_loc),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_num      (rd_num),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .ovf_err     (ovf_err),
        .udf_err     (udf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given request, then all strobes dropped.
    task automatic cyc(input logic we, input int wn, input logic [127:0] d0, input logic [127:0] d1,
                       input logic re, input int rn, input logic fl);
        wr_en   = we;
        wr_num  = wn[1:0];
        wr_data = {d1, d0};
        rd_en   = re;
        rd_num  = rn[2:0];
        flush   = fl;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
    endtask

    function automatic logic [127:0] slot(input int i);
        return rd_data[i*128 +: 128];
    endfunction

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_num = '0; wr_data = '0;
        rd_en = 1'b0; rd_num = '0;
        #3;
        chk("rst_count", 128'(count), 0);
        chk("rst_empty", 128'(empty_loc), 256);
        chk("rst_af", 128'(almost_full), 0);
        chk("rst_rd_valid", 128'(rd_valid), 0);
        chk("rst_rd_data_nz", 128'(rd_data != '0), 0);
        chk("rst_ovf", 128'(ovf_err), 0);
        chk("rst_udf", 128'(udf_err), 0);
        tick();
        arst_n = 1'b1;

        // Read from empty
        cyc(0, 0, 0, 0, 1, 1, 0);
        chk("empty_rd_udf", 128'(udf_err), 1);
        chk("empty_rd_count", 128'(count), 0);
        chk("empty_rd_ovf", 128'(ovf_err), 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("flush_udf_clr", 128'(udf_err), 0);

        // A,B then C, read 3
        cyc(1, 2, DA, DB, 0, 0, 0);
        chk("wr2_count", 128'(count), 2);
        cyc(1, 1, DC, 0, 0, 0, 0);
        chk("wr3_count", 128'(count), 3);
        chk("wr3_empty", 128'(empty_loc), 253);
        rd_en = 1'b1; rd_num = 3'd3;
`ifndef TLP_BUF_RD_REG_EN
        #1;
        chk("rd3_valid", 128'(rd_valid), 1);
        chk("rd3_s0", slot(0), DA);
        chk("rd3_s1", slot(1), DB);
        chk("rd3_s2", slot(2), DC);
        chk("rd3_s3", slot(3), 0);
`endif
        tick();
        rd_en = 1'b0;
`ifdef TLP_BUF_RD_REG_EN
        chk("rd3_valid", 128'(rd_valid), 1);
        chk("rd3_s0", slot(0), DA);
        chk("rd3_s1", slot(1), DB);
        chk("rd3_s2", slot(2), DC);
        chk("rd3_s3", slot(3), 0);
`endif
        chk("rd3_count", 128'(count), 0);
`ifdef TLP_BUF_RD_REG_EN
        tick();
        chk("rd3_valid_drop", 128'(rd_valid), 0);
        chk("rd3_hold_s0", slot(0), DA);
`else
        #1;
        chk("rd3_valid_drop", 128'(rd_valid), 0);
        chk("rd3_after_s0", slot(0), 0);
`endif

        // Fill to full; loc k holds 0x100+k
        for (int k = 0; k < 124; k++)
            cyc(1, 2, 128'(256 + 2*k), 128'(257 + 2*k), 0, 0, 0);
        chk("fill248_count", 128'(count), 248);
        chk("fill248_empty", 128'(empty_loc), 8);
        chk("fill248_af", 128'(almost_full), 0);
        cyc(1, 1, 128'(256 + 248), 0, 0, 0, 0);
        chk("fill249_af", 128'(almost_full), 1);
        for (int k = 0; k < 3; k++)
            cyc(1, 2, 128'(256 + 249 + 2*k), 128'(256 + 250 + 2*k), 0, 0, 0);
        chk("fill255_count", 128'(count), 255);
        chk("fill255_ovf", 128'(ovf_err), 0);
        cyc(1, 2, 128'hBAD0, 128'hBAD1, 0, 0, 0);
        chk("ovf2_flag", 128'(ovf_err), 1);
        chk("ovf2_count", 128'(count), 255);
        cyc(1, 1, 128'(256 + 255), 0, 0, 0, 0);
        chk("full_count", 128'(count), 256);
        chk("full_empty", 128'(empty_loc), 0);
        chk("full_af", 128'(almost_full), 1);
`ifndef TLP_BUF_RD_REG_EN
        chk("full_s0", slot(0), 128'h100);
        chk("full_s3", slot(3), 128'h103);
`endif
        cyc(1, 1, 128'hBAD2, 0, 1, 1, 0);
        chk("full_rw_count", 128'(count), 255);
`ifdef TLP_BUF_RD_REG_EN
        chk("full_rw_s0", slot(0), 128'h100);
`else
        chk("full_rw_s0", slot(0), 128'h101);
`endif

        // Wrap: park both pointers at 255
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("flush2_count", 128'(count), 0);
        chk("flush2_ovf", 128'(ovf_err), 0);
        for (int k = 0; k < 127; k++)
            cyc(1, 2, 128'(k), 128'(k), 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 63; k++)
            cyc(0, 0, 0, 0, 1, 4, 0);
        cyc(0, 0, 0, 0, 1, 3, 0);
        chk("wrap_pre_count", 128'(count), 0);
        chk("wrap_pre_udf", 128'(udf_err), 0);
        cyc(1, 2, DD, DE, 0, 0, 0);
        chk("wrap_wr_count", 128'(count), 2);
        rd_en = 1'b1; rd_num = 3'd2;
`ifndef TLP_BUF_RD_REG_EN
        #1;
        chk("wrap_valid", 128'(rd_valid), 1);
        chk("wrap_s0", slot(0), DD);
        chk("wrap_s1", slot(1), DE);
        chk("wrap_s2", slot(2), 0);
`endif
        tick();
        rd_en = 1'b0;
`ifdef TLP_BUF_RD_REG_EN
        chk("wrap_valid", 128'(rd_valid), 1);
        chk("wrap_s0", slot(0), DD);
        chk("wrap_s1", slot(1), DE);
        chk("wrap_s2", slot(2), 0);
`endif
        chk("wrap_count", 128'(count), 0);

        // Simultaneous write 2 / read 4 at count 3
        cyc(1, 2, DA, DB, 0, 0, 0);
        cyc(1, 1, DC, 0, 0, 0, 0);
        cyc(1, 2, DD, DE, 1, 4, 0);
        chk("simul_udf", 128'(udf_err), 1);
        chk("simul_ovf", 128'(ovf_err), 0);
        chk("simul_count", 128'(count), 5);

        // Out-of-range counts, then flush with requests pending
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("flush3_udf", 128'(udf_err), 0);
        for (int k = 0; k < 5; k++)
            cyc(1, 2, DA, DB, 0, 0, 0);
        chk("ten_count", 128'(count), 10);
        cyc(1, 3, DA, DB, 0, 0, 0);
        chk("wrnum3_ovf", 128'(ovf_err), 1);
        chk("wrnum3_count", 128'(count), 10);
        cyc(0, 0, 0, 0, 1, 5, 0);
        chk("rdnum5_udf", 128'(udf_err), 1);
        chk("rdnum5_count", 128'(count), 10);
        cyc(1, 2, DC, DD, 1, 1, 1);
        chk("flushrw_count", 128'(count), 0);
        chk("flushrw_empty", 128'(empty_loc), 256);
        chk("flushrw_ovf", 128'(ovf_err), 0);
        chk("flushrw_udf", 128'(udf_err), 0);
        chk("flushrw_af", 128'(almost_full), 0);
        cyc(0, 0, 0, 0, 1, 1, 0);
        chk("post_flush_rd_udf", 128'(udf_err), 1);
        chk("post_flush_count", 128'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tlp_frag_multi_buffer.md
# tlp_frag_multi_buffer

Parametrised circular TLP buffer sitting between the TX arbiter and the data-fragmentation stage. Each cycle it accepts a variable number of locations (1..WR_LOCS) and releases a variable number (1..RD_LOCS), replacing the fixed one-or-two-location read mode with an arbitrary read count. It also adds flush, almost-full, and sticky overflow/underflow error reporting. Occupancy (`count`) and free space (`empty_loc`) are exported for flow control on both sides.

## Interface
Parameters:
- `LOC_WIDTH`, 128, bits per buffer location
- `DEPTH`, 256, number of locations; power of two, ≥ 2·max(WR_LOCS, RD_LOCS)
- `WR_LOCS`, 2, maximum locations written per cycle
- `RD_LOCS`, 4, maximum locations read per cycle
- `AF_THRESH`, 8, `almost_full` asserts when `empty_loc` < AF_THRESH
- derived: `CNT_W` = $clog2(DEPTH)+1, `WR_NUM_W` = $clog2(WR_LOCS+1), `RD_NUM_W` = $clog2(RD_LOCS+1)

Ports (one clock `clk`; reset `arst_n` is asynchronous, active-low):
- `clk`  in  1  clock
- `arst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous clear of pointers, count and error flags
- `wr_en`  in  1  write request
- `wr_num`  in  WR_NUM_W  locations to write; slot i is `wr_data[i*LOC_WIDTH +: LOC_WIDTH]`; slot 0 is stored first
- `wr_data`  in  WR_LOCS*LOC_WIDTH  write payload
- `empty_loc`  out  CNT_W  free locations
- `almost_full`  out  1  `empty_loc` < AF_THRESH
- `rd_en`  in  1  read request
- `rd_num`  in  RD_NUM_W  locations to pop
- `rd_data`  out  RD_LOCS*LOC_WIDTH  slot i = i-th oldest location
- `rd_valid`  out  1  `rd_data` carries an accepted read
- `count`  out  CNT_W  stored locations
- `ovf_err`  out  1  sticky; a write was rejected
- `udf_err`  out  1  sticky; a read was rejected

## Operation
- Storage: DEPTH×LOC_WIDTH array. `wr_ptr` and `rd_ptr` each have $clog2(DEPTH) bits and wrap modulo DEPTH. Multi-location accesses straddle the wrap point seamlessly.
- Write acceptance: `wr_acc` = `wr_en` & (`wr_num` ≠ 0) & (`wr_num` ≤ `empty_loc`), using the pre-cycle `empty_loc`. A same-cycle read never frees space for that write.
- Rejected write (`wr_en` & `wr_num` > `empty_loc`): nothing stored, pointers unchanged, `ovf_err` ← 1.
- Read acceptance: `rd_acc` = `rd_en` & (`rd_num` ≠ 0) & (`rd_num` ≤ `count`), using the pre-cycle `count`. A same-cycle write never supplies data for that read.
- Rejected read: pointers unchanged, `udf_err` ← 1, `rd_valid` = 0.
- `wr_num` = 0 or `rd_num` = 0: no-op, no error.
- Update: `count_next` = `count` + (`wr_acc` ? `wr_num` : 0) − (`rd_acc` ? `rd_num` : 0). `empty_loc` = DEPTH − `count` at all times.
- `wr_num` > WR_LOCS or `rd_num` > RD_LOCS: treated as rejected (error set).
- `flush` takes priority over `wr_en`/`rd_en` in the same cycle. On flush:
  - pointers and `count` go to 0
  - `ovf_err`/`udf_err` clear
  - memory contents are not cleared
- `rd_data` slots at index ≥ the number of valid locations read as 0.

## Timing
- Reset values: `count` = 0, `empty_loc` = DEPTH, `almost_full` = 0 (when AF_THRESH ≤ DEPTH), `rd_data` = 0, `rd_valid` = 0, `ovf_err` = 0, `udf_err` = 0.
- Reset mid-transfer discards all content immediately (asynchronous).
- Write-to-read latency: data written in cycle N is visible in `count` and readable from cycle N+1.
- `count`, `empty_loc` and `almost_full` are registered-derived and update the cycle after the accepting edge.
- Error flags set on the edge of the rejected request and hold until `flush` or reset.
- Full at DEPTH: any write with `wr_num` ≥ 1 is rejected, even alongside a same-cycle read.

## Configuration
- `TLP_BUF_RD_REG_EN` defined:
  - `rd_data` is a register loaded on the `rd_acc` edge with the popped locations
  - `rd_valid` is a one-cycle pulse in the cycle after acceptance
  - `rd_data` holds its value otherwise
- Not defined (show-ahead):
  - `rd_data` is combinational; slot i = mem[`rd_ptr`+i] for i < `count`, else 0
  - `rd_valid` = `rd_acc` in the same cycle
  - the consumer samples `rd_data` in the same cycle it asserts `rd_en`

## Test plan
- Reset then idle: `count` = 0, `empty_loc` = 256, all flags 0; `rd_en` with `rd_num` = 1 → `udf_err` = 1, `count` stays 0.
- Write A,B (`wr_num` = 2), then C (`wr_num` = 1); read `rd_num` = 3 → slots 0..2 = A,B,C, slot 3 = 0, `count` = 0 afterwards. Covers both macro settings with their respective `rd_valid` timing.
- Fill to 255, then `wr_num` = 2 → rejected, `ovf_err` = 1, `count` = 255; `wr_num` = 1 → `count` = 256, `empty_loc` = 0, `almost_full` = 1.
- Wrap: advance pointers to 255, write 2 locations, read 2 → data returned in order across the wrap, `count` back to 0.
- Simultaneous: `count` = 3, write 2 and read 4 in the same cycle → read rejected (`udf_err` = 1), write accepted, `count` = 5.
- Flush with `wr_en` and `rd_en` asserted at `count` = 10 and `ovf_err` = 1 → next cycle `count` = 0, `empty_loc` = 256, `ovf_err` = 0, nothing written.
